// File: rtl/load_store_unit.sv
// RV32 load/store unit: drives a word-aligned req/gnt data bus, steers byte
// lanes, extends load data and reports misaligned accesses or bus timeouts.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    output logic        resp_valid_o,
    output logic [31:0] load_data_o,
    output logic        misaligned_o,
    output logic        bus_error_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_byte_en_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_R
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          is_store_q;
    logic [2:0]    funct3_q;
    logic [1:0]    off_q;

    logic          bad;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [15:0]   lane;
    logic [31:0]   ext;
    logic          timeout_hit;

    assign req_ready_o = (state == IDLE);
    assign timeout_hit = TO_EN && (cnt >= LAST);

    // Request decode: lane enables, replicated write data, legality
    always_comb begin
        bad   = 1'b0;
        be    = 4'b0000;
        wdata = 32'h0;
        case (funct3_i[1:0])
            2'b00: begin
                be    = 4'b0001 << addr_i[1:0];
                wdata = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << addr_i[1:0];
                wdata = {2{store_data_i[15:0]}};
                bad   = addr_i[0];
            end
            2'b10: begin
                be    = 4'b1111;
                wdata = store_data_i;
                bad   = (addr_i[1:0] != 2'b00);
            end
            default: bad = 1'b1;
        endcase
        if (funct3_i[2] && (is_store_i || funct3_i[1])) begin
            bad = 1'b1;
        end
    end

    always_comb begin
        lane = 16'h0;
        case (off_q)
            2'd0: lane = mem_rdata_i[15:0];
            2'd1: lane = {8'h00, mem_rdata_i[15:8]};
            2'd2: lane = mem_rdata_i[31:16];
            default: lane = {8'h00, mem_rdata_i[31:24]};
        endcase
    end

    always_comb begin
        ext = mem_rdata_i;
        case (funct3_q)
            3'b000: ext = {{24{lane[7]}}, lane[7:0]};
            3'b001: ext = {{16{lane[15]}}, lane[15:0]};
            3'b100: ext = {24'h0, lane[7:0]};
            3'b101: ext = {16'h0, lane[15:0]};
            default: ext = mem_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state         <= IDLE;
            cnt           <= '0;
            is_store_q    <= 1'b0;
            funct3_q      <= 3'b000;
            off_q         <= 2'b00;
            resp_valid_o  <= 1'b0;
            load_data_o   <= 32'h0;
            misaligned_o  <= 1'b0;
            bus_error_o   <= 1'b0;
            mem_req_o     <= 1'b0;
            mem_we_o      <= 1'b0;
            mem_byte_en_o <= 4'b0000;
            mem_addr_o    <= 32'h0;
            mem_wdata_o   <= 32'h0;
        end else begin
            resp_valid_o <= 1'b0;
            load_data_o  <= 32'h0;
            misaligned_o <= 1'b0;
            bus_error_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        is_store_q <= is_store_i;
                        funct3_q   <= funct3_i;
                        off_q      <= addr_i[1:0];
                        if (bad) begin
                            resp_valid_o <= 1'b1;
                            misaligned_o <= 1'b1;
                        end else begin
                            state         <= REQ;
                            cnt           <= '0;
                            mem_req_o     <= 1'b1;
                            mem_we_o      <= is_store_i;
                            mem_byte_en_o <= be;
                            mem_addr_o    <= {addr_i[31:2], 2'b00};
                            mem_wdata_o   <= wdata;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt_i || timeout_hit) begin
                        mem_req_o     <= 1'b0;
                        mem_we_o      <= 1'b0;
                        mem_byte_en_o <= 4'b0000;
                        mem_addr_o    <= 32'h0;
                        mem_wdata_o   <= 32'h0;
                    end
                    // A grant in the expiry cycle still completes normally
                    if (mem_gnt_i) begin
                        if (is_store_q) begin
                            state        <= IDLE;
                            resp_valid_o <= 1'b1;
                        end else begin
                            state <= WAIT_R;
                            cnt   <= cnt + 1'b1;
                        end
                    end else if (timeout_hit) begin
                        state        <= IDLE;
                        resp_valid_o <= 1'b1;
                        bus_error_o  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_R: begin
                    if (mem_rvalid_i) begin
                        state        <= IDLE;
                        resp_valid_o <= 1'b1;
                        load_data_o  <= ext;
                    end else if (timeout_hit) begin
                        state        <= IDLE;
                        resp_valid_o <= 1'b1;
                        bus_error_o  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized
// transactions checked against a lane/size arithmetic reference model.
module tb_load_store_unit;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        req_valid;
    logic        req_valid4;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic        req_ready, resp_valid, misaligned, bus_error;
    logic        mem_req, mem_we;
    logic [3:0]  mem_byte_en;
    logic [31:0] load_data, mem_addr, mem_wdata;

    logic        t4_ready, t4_resp, t4_mis, t4_bus, t4_req, t4_we;
    logic [3:0]  t4_be;
    logic [31:0] t4_data, t4_addr, t4_wdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .is_store_i(is_store), .funct3_i(funct3),
        .addr_i(addr), .store_data_i(store_data),
        .resp_valid_o(resp_valid), .load_data_o(load_data),
        .misaligned_o(misaligned), .bus_error_o(bus_error),
        .mem_req_o(mem_req), .mem_we_o(mem_we),
        .mem_byte_en_o(mem_byte_en), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
    );

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut4 (
        .clk_i(clk), .reset_i(reset_i),
        .req_valid_i(req_valid4), .req_ready_o(t4_ready),
        .is_store_i(is_store), .funct3_i(funct3),
        .addr_i(addr), .store_data_i(store_data),
        .resp_valid_o(t4_resp), .load_data_o(t4_data),
        .misaligned_o(t4_mis), .bus_error_o(t4_bus),
        .mem_req_o(t4_req), .mem_we_o(t4_we),
        .mem_byte_en_o(t4_be), .mem_addr_o(t4_addr),
        .mem_wdata_o(t4_wdata), .mem_gnt_i(mem_gnt),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    // Reference: access legality, lanes covered and replicated store bytes
    function automatic void model(input logic st, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] d,
                                  output logic bad, output logic [3:0] be,
                                  output logic [31:0] wd);
        int sz;
        int off;
        sz  = size_of(f3);
        off = int'(a % 4);
        be  = 4'b0000;
        wd  = 32'h0;
        if (sz == 0) bad = 1'b1;
        else bad = (st && f3[2]) || ((off % sz) != 0);
        if (!bad) begin
            for (int i = 0; i < 4; i++) begin
                be[i] = (i >= off) && (i < off + sz);
                wd[8*i +: 8] = d[8*(i % sz) +: 8];
            end
        end
    endfunction

    function automatic logic [31:0] ld_exp(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
        longint v;
        longint lim;
        int sz;
        sz  = size_of(f3);
        v   = longint'(rd >> (8 * (a % 4)));
        lim = longint'(1) << (8 * sz);
        v   = v % lim;
        if (!f3[2] && sz < 4 && v >= lim / 2) v = v - lim;
        return v[31:0];
    endfunction

    // One request from IDLE; returns in the response cycle
    task automatic do_txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] rd,
                          input int gd, input int rvd);
        logic bad;
        logic [3:0] be;
        logic [31:0] wd;
        model(st, f3, a, d, bad, be, wd);
        check1("start_ready", req_ready, 1'b1);
        req_valid  = 1'b1;
        is_store   = st;
        funct3     = f3;
        addr       = a;
        store_data = d;
        step();
        req_valid  = 1'b0;
        is_store   = 1'($urandom);
        funct3     = 3'($urandom);
        addr       = $urandom;
        store_data = $urandom;
        if (bad) begin
            check1("mis_resp", resp_valid, 1'b1);
            check1("mis_flag", misaligned, 1'b1);
            check1("mis_bus", bus_error, 1'b0);
            check("mis_data", load_data, 32'h0);
            check1("mis_memreq", mem_req, 1'b0);
            return;
        end
        for (int n = 0; n < TO; n++) begin
            check1("req", mem_req, 1'b1);
            check1("we", mem_we, st);
            check("byte_en", {28'h0, mem_byte_en}, {28'h0, be});
            check("mem_addr", mem_addr, {a[31:2], 2'b00});
            if (st) check("wdata", mem_wdata, wd);
            check1("busy_resp", resp_valid, 1'b0);
            check1("busy_ready", req_ready, 1'b0);
            if (n == gd) begin
                mem_gnt = 1'b1;
                if (!st) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = ~rd;
                end
            end
            step();
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            if (n == gd) break;
        end
        if (gd >= TO) begin
            check1("to_resp", resp_valid, 1'b1);
            check1("to_bus", bus_error, 1'b1);
            check1("to_mis", misaligned, 1'b0);
            check("to_data", load_data, 32'h0);
            check1("to_memreq", mem_req, 1'b0);
            return;
        end
        if (!st) begin
            for (int j = 1; j <= rvd; j++) begin
                check1("wait_req", mem_req, 1'b0);
                check1("wait_resp", resp_valid, 1'b0);
                mem_rvalid = (j == rvd);
                mem_rdata  = (j == rvd) ? rd : $urandom;
                step();
                mem_rvalid = 1'b0;
            end
        end
        check1("resp", resp_valid, 1'b1);
        check1("resp_mis", misaligned, 1'b0);
        check1("resp_bus", bus_error, 1'b0);
        check("load_data", load_data, st ? 32'h0 : ld_exp(f3, a, rd));
        check1("resp_memreq", mem_req, 1'b0);
    endtask

    initial begin
        reset_i    = 1'b1;
        req_valid  = 1'b0;
        req_valid4 = 1'b0;
        is_store   = 1'b0;
        funct3     = 3'b000;
        addr       = 32'h0;
        store_data = 32'h0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        step();
        check1("rst_ready", req_ready, 1'b1);
        check1("rst_resp", resp_valid, 1'b0);
        check1("rst_req", mem_req, 1'b0);
        check("rst_data", load_data, 32'h0);
        check("rst_be", {28'h0, mem_byte_en}, 32'h0);
        check1("rst4_ready", t4_ready, 1'b1);
        reset_i = 1'b0;
        step();

        do_txn(1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 0, 1);
        do_txn(1'b0, 3'b000, 32'h102, 32'h0, 32'h12803456, 0, 1);
        do_txn(1'b0, 3'b100, 32'h102, 32'h0, 32'h12803456, 0, 1);
        do_txn(1'b0, 3'b101, 32'h102, 32'h0, 32'h12803456, 0, 1);
        do_txn(1'b0, 3'b010, 32'h106, 32'h0, 32'h0, 0, 1);
        do_txn(1'b1, 3'b001, 32'h001, 32'h1234, 32'h0, 0, 1);
        do_txn(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 1);
        do_txn(1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 0, 1);
        do_txn(1'b0, 3'b010, 32'h108, 32'h0, 32'hCAFEF00D, 3, 2);
        do_txn(1'b1, 3'b010, 32'h10C, 32'h12345678, 32'h0, TO - 1, 1);
        do_txn(1'b1, 3'b001, 32'h10E, 32'h0000BEEF, 32'h0, TO + 5, 1);
        do_txn(1'b0, 3'b001, 32'h10E, 32'h0, 32'h8001_7FFF, 1, 3);

        for (int k = 0; k < 80; k++) begin
            do_txn(1'($urandom), 3'($urandom), {20'h00001, 12'($urandom)},
                   $urandom, $urandom, int'($urandom_range(0, 4)),
                   int'($urandom_range(1, 4)));
        end
        step();
        check1("idle_resp", resp_valid, 1'b0);

        // Short-timeout instance: grant never arrives
        is_store   = 1'b0;
        funct3     = 3'b010;
        addr       = 32'h200;
        req_valid4 = 1'b1;
        step();
        req_valid4 = 1'b0;
        for (int n = 0; n < 4; n++) begin
            check1("t4_req", t4_req, 1'b1);
            check("t4_addr", t4_addr, 32'h200);
            check1("t4_busy", t4_resp, 1'b0);
            step();
        end
        check1("t4_req_drop", t4_req, 1'b0);
        check1("t4_resp", t4_resp, 1'b1);
        check1("t4_bus", t4_bus, 1'b1);
        check1("t4_mis", t4_mis, 1'b0);
        check1("t4_ready", t4_ready, 1'b1);
        is_store   = 1'b1;
        addr       = 32'h204;
        store_data = 32'hDEADBEEF;
        req_valid4 = 1'b1;
        step();
        req_valid4 = 1'b0;
        check1("t4_req2", t4_req, 1'b1);
        check1("t4_we2", t4_we, 1'b1);
        check("t4_wdata2", t4_wdata, 32'hDEADBEEF);
        check("t4_be2", {28'h0, t4_be}, 32'hF);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        check1("t4_resp2", t4_resp, 1'b1);
        check1("t4_bus2", t4_bus, 1'b0);
        check("t4_data2", t4_data, 32'h0);
        step();

        // Reset while waiting for read data
        is_store  = 1'b0;
        funct3    = 3'b010;
        addr      = 32'h300;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        check1("r_req", mem_req, 1'b1);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        check1("r_wait_ready", req_ready, 1'b0);
        #2 reset_i = 1'b1;
        #1;
        check1("r_async_ready", req_ready, 1'b1);
        check1("r_async_resp", resp_valid, 1'b0);
        check1("r_async_req", mem_req, 1'b0);
        step();
        check1("r_hold_ready", req_ready, 1'b1);
        check("r_hold_data", load_data, 32'h0);
        reset_i    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h55AA55AA;
        step();
        mem_rvalid = 1'b0;
        check1("r_late_resp", resp_valid, 1'b0);
        check("r_late_data", load_data, 32'h0);
        check1("r_late_ready", req_ready, 1'b1);
        step();
        check1("r_late_resp2", resp_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
